// File: rtl/freq_sweep_controller_pkg.sv
// Shared definitions for the frequency sweep sequencer and its DDFS neighbours.
package freq_sweep_controller_pkg;
  localparam int SWP_FREQ_W  = 23;
  localparam int SWP_DWELL_W = 16;

  typedef enum logic [1:0] {
    SWP_IDLE  = 2'd0,
    SWP_RUN   = 2'd1,
    SWP_PAUSE = 2'd2,
    SWP_DONE  = 2'd3
  } swp_state_t;

  localparam logic [1:0] SWP_SINGLE   = 2'd0;
  localparam logic [1:0] SWP_REPEAT   = 2'd1;
  localparam logic [1:0] SWP_TRIANGLE = 2'd2;
endpackage

// File: rtl/freq_sweep_controller_sweep_next_freq.sv
// One step of a sweep toward a target, clamped so the target is never overshot.
module sweep_next_freq #(
  parameter int FREQ_W = 23
) (
  input  logic [FREQ_W-1:0] cur,
  input  logic [FREQ_W-1:0] target,
  input  logic [FREQ_W-1:0] step,
  input  logic              dir,
  output logic [FREQ_W-1:0] next,
  output logic              at_end
);
  logic [FREQ_W-1:0] diff;

  // Distance to target in the direction of travel; comparing it avoids overflow.
  assign diff   = dir ? (target - cur) : (cur - target);
  assign next   = (diff <= step) ? target : (dir ? cur + step : cur - step);
  assign at_end = (cur == target);
endmodule

// File: rtl/freq_sweep_controller.sv
// Steps the DDFS frequency word between two endpoints with per-value dwell.
module freq_sweep_controller
  import freq_sweep_controller_pkg::*;
#(
  parameter int FREQ_W  = SWP_FREQ_W,
  parameter int DWELL_W = SWP_DWELL_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               start,
  input  logic               abort,
  input  logic               pause,
  input  logic [1:0]         mode,
  input  logic [FREQ_W-1:0]  start_freq,
  input  logic [FREQ_W-1:0]  stop_freq,
  input  logic [FREQ_W-1:0]  step_freq,
  input  logic [DWELL_W-1:0] dwell_len,
  output logic [FREQ_W-1:0]  freq,
  output logic               freq_upd,
  output logic               dir_up,
  output logic               busy,
  output logic               done
);
  typedef struct packed {
    logic [FREQ_W-1:0]  start_f;
    logic [FREQ_W-1:0]  stop_f;
    logic [FREQ_W-1:0]  step_f;
    logic [DWELL_W-1:0] dwell;
    logic [1:0]         mode;
  } swp_cfg_t;

  swp_state_t         state, state_n;
  swp_cfg_t           cfg, cfg_n;
  logic [FREQ_W-1:0]  freq_n;
  logic               upd_n, dir_n, done_n;
  logic [DWELL_W-1:0] cnt, cnt_n;
  logic               tsel, tsel_n;  // 1: current target is start_f (triangle return leg)

  // Evaluator 0 steps toward the current target, evaluator 1 toward the opposite one.
  logic [1:0][FREQ_W-1:0] tgt_v, nxt_v;
  logic [1:0]             dir_v, end_v;
  logic                   at_end;

  assign tgt_v[0] = tsel ? cfg.start_f : cfg.stop_f;
  assign tgt_v[1] = tsel ? cfg.stop_f  : cfg.start_f;
  assign dir_v[0] = dir_up;
  assign dir_v[1] = ~dir_up;

  genvar g;
  generate
    for (g = 0; g < 2; g++) begin : g_nf
      sweep_next_freq #(.FREQ_W(FREQ_W)) u_nf (
        .cur    (freq),
        .target (tgt_v[g]),
        .step   (cfg.step_f),
        .dir    (dir_v[g]),
        .next   (nxt_v[g]),
        .at_end (end_v[g])
      );
    end
  endgenerate

  // A zero step can never reach the target, so treat every value as the end point.
  assign at_end = end_v[0] | (cfg.step_f == '0);
  assign busy   = (state == SWP_RUN) || (state == SWP_PAUSE);

  always_comb begin
    state_n = state;
    cfg_n   = cfg;
    freq_n  = freq;
    upd_n   = 1'b0;
    dir_n   = dir_up;
    done_n  = done;
    cnt_n   = cnt;
    tsel_n  = tsel;
    if (abort) begin
      state_n = SWP_IDLE;
      done_n  = 1'b0;
    end else if (start) begin
      cfg_n   = '{start_f: start_freq, stop_f: stop_freq, step_f: step_freq,
                  dwell: dwell_len, mode: mode};
      freq_n  = start_freq;
      upd_n   = 1'b1;
      cnt_n   = '0;
      dir_n   = (stop_freq >= start_freq);
      tsel_n  = 1'b0;
      state_n = SWP_RUN;
      done_n  = 1'b0;
    end else begin
      case (state)
        SWP_RUN: begin
          if (pause) begin
            state_n = SWP_PAUSE;
          end else if (tick) begin
            if (cnt < cfg.dwell) begin
              cnt_n = cnt + 1'b1;
            end else begin
              cnt_n = '0;
              if (!at_end) begin
                freq_n = nxt_v[0];
                upd_n  = 1'b1;
              end else begin
                case (cfg.mode)
                  SWP_REPEAT: begin
                    freq_n = cfg.start_f;
                    upd_n  = 1'b1;
                  end
                  SWP_TRIANGLE: begin
                    freq_n = nxt_v[1];
                    upd_n  = 1'b1;
                    // Opposite endpoint equal to this one means nothing to reverse.
                    if (!end_v[1]) begin
                      dir_n  = ~dir_up;
                      tsel_n = ~tsel;
                    end
                  end
                  default: begin
                    state_n = SWP_DONE;
                    done_n  = 1'b1;
                  end
                endcase
              end
            end
          end
        end
        SWP_PAUSE: if (!pause) state_n = SWP_RUN;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= SWP_IDLE;
      cfg      <= '0;
      freq     <= '0;
      freq_upd <= 1'b0;
      dir_up   <= 1'b1;
      done     <= 1'b0;
      cnt      <= '0;
      tsel     <= 1'b0;
    end else begin
      state    <= state_n;
      cfg      <= cfg_n;
      freq     <= freq_n;
      freq_upd <= upd_n;
      dir_up   <= dir_n;
      done     <= done_n;
      cnt      <= cnt_n;
      tsel     <= tsel_n;
    end
  end
endmodule

// File: tb/tb_freq_sweep_controller.sv
// Directed bench: expected freq/dir pushed on stimulus, popped by a freq_upd monitor.
module tb_freq_sweep_controller;
  logic        clk = 1'b0, rst = 1'b1;
  logic        tick = 1'b0, start = 1'b0, abort = 1'b0, pause = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [22:0] start_freq = '0, stop_freq = '0, step_freq = '0;
  logic [15:0] dwell_len = '0;
  logic [22:0] freq;
  logic        freq_upd, dir_up, busy, done;

  typedef struct packed { logic [22:0] f; logic d; } exp_t;
  exp_t exp_q[$];
  int   n_tests = 0, n_fail = 0;

  freq_sweep_controller dut (
    .clk(clk), .rst(rst), .tick(tick), .start(start), .abort(abort), .pause(pause),
    .mode(mode), .start_freq(start_freq), .stop_freq(stop_freq), .step_freq(step_freq),
    .dwell_len(dwell_len), .freq(freq), .freq_upd(freq_upd), .dir_up(dir_up),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input int f, input bit d);
    exp_q.push_back('{f: 23'(f), d: d});
  endtask

  task automatic do_start(input logic [1:0] m, input int s, input int e, input int st,
                          input int dw);
    @(negedge clk);
    mode = m; start_freq = 23'(s); stop_freq = 23'(e); step_freq = 23'(st);
    dwell_len = 16'(dw); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic ticks(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); tick = 1'b1;
      @(negedge clk); tick = 1'b0;
      repeat (gap - 1) @(negedge clk);
    end
  endtask

  // Monitor: every freq_upd must match the next expected entry.
  always @(negedge clk) begin
    if (!rst && freq_upd) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_upd", int'(freq), -1);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_freq", int'(freq), int'(e.f));
        chk("sb_dir", int'(dir_up), int'(e.d));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_freq", int'(freq), 0);
    chk("rst_dir", int'(dir_up), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    rst = 1'b0;

    // Single ascending, tick every 4 clocks, 3 ticks per value.
    push(1000, 1); push(1100, 1); push(1200, 1); push(1300, 1);
    do_start(2'd0, 1000, 1300, 100, 2);
    chk("t1_busy", int'(busy), 1);
    ticks(2, 4);
    chk("t1_hold", int'(freq), 1000);
    ticks(1, 4);
    chk("t1_step", int'(freq), 1100);
    ticks(9, 4);
    chk("t1_done", int'(done), 1);
    chk("t1_busy_end", int'(busy), 0);
    chk("t1_freq_end", int'(freq), 1300);

    // Descending with overshoot clamp.
    push(500, 0); push(300, 0); push(120, 0);
    do_start(2'd0, 500, 120, 200, 0);
    chk("t2_done_clr", int'(done), 0);
    ticks(3, 2);
    chk("t2_done", int'(done), 1);
    chk("t2_dir", int'(dir_up), 0);
    chk("t2_freq", int'(freq), 120);

    // Triangle ping-pong.
    push(10, 1); push(20, 1); push(30, 1); push(20, 0);
    push(10, 0); push(20, 1); push(30, 1); push(20, 0);
    do_start(2'd2, 10, 30, 10, 0);
    ticks(7, 3);
    chk("t3_busy", int'(busy), 1);
    chk("t3_done", int'(done), 0);

    // Repeat with pause mid-dwell.
    push(0, 1);
    do_start(2'd1, 0, 2, 1, 1);
    ticks(1, 2);
    @(negedge clk); pause = 1'b1;
    @(negedge clk);
    ticks(10, 2);
    chk("t4_frozen", int'(freq), 0);
    chk("t4_busy", int'(busy), 1);
    push(1, 1); push(2, 1); push(0, 1); push(1, 1);
    pause = 1'b0;
    @(negedge clk);
    ticks(1, 2);
    chk("t4_resume", int'(freq), 1);
    ticks(6, 2);
    chk("t4_freq", int'(freq), 1);

    // start + abort together: abort wins.
    @(negedge clk);
    start = 1'b1; abort = 1'b1; start_freq = 23'd77;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("t5_busy", int'(busy), 0);
    chk("t5_freq", int'(freq), 1);
    chk("t5_done", int'(done), 0);
    push(400, 1);
    do_start(2'd1, 400, 800, 100, 3);
    ticks(1, 2);
    push(600, 1);
    do_start(2'd1, 600, 800, 100, 3);
    chk("t5_restart", int'(freq), 600);

    // Async reset between clock edges.
    push(900, 0);
    do_start(2'd0, 900, 100, 100, 5);
    ticks(2, 2);
    chk("t6_pre_dir", int'(dir_up), 0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t6_freq", int'(freq), 0);
    chk("t6_dir", int'(dir_up), 1);
    chk("t6_busy", int'(busy), 0);
    chk("t6_upd", int'(freq_upd), 0);
    @(negedge clk); rst = 1'b0;

    // Degenerate zero step, single.
    push(55, 1);
    do_start(2'd0, 55, 99, 0, 2);
    ticks(2, 2);
    chk("t7_done_early", int'(done), 0);
    chk("t7_freq", int'(freq), 55);
    ticks(1, 2);
    chk("t7_done", int'(done), 1);
    chk("t7_busy", int'(busy), 0);

    repeat (3) @(negedge clk);
    chk("sb_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
